// File: rtl/mem_wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing one memory-side slave port.
// The grant is registered; the losing master sees RTY while it requests.
module mem_wishbone_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_CYC,
  input  logic                  i_STB,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_ADR,
  input  logic [SEL_WIDTH-1:0]  i_SEL,
  input  logic [DATA_WIDTH-1:0] i_DAT_M,
  output logic [DATA_WIDTH-1:0] i_DAT_S,
  output logic                  i_ACK,
  output logic                  i_RTY,
  input  logic                  d_CYC,
  input  logic                  d_STB,
  input  logic                  d_WE,
  input  logic [ADDR_WIDTH-1:0] d_ADR,
  input  logic [SEL_WIDTH-1:0]  d_SEL,
  input  logic [DATA_WIDTH-1:0] d_DAT_M,
  output logic [DATA_WIDTH-1:0] d_DAT_S,
  output logic                  d_ACK,
  output logic                  d_RTY,
  output logic                  m_CYC,
  output logic                  m_STB,
  output logic                  m_WE,
  output logic [ADDR_WIDTH-1:0] m_ADR,
  output logic [SEL_WIDTH-1:0]  m_SEL,
  output logic [DATA_WIDTH-1:0] m_DAT_M,
  input  logic [DATA_WIDTH-1:0] m_DAT_S,
  input  logic                  m_ACK,
  input  logic                  m_RTY,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   last, last_nx;
  logic   i_req, d_req;

  assign i_req = i_CYC & i_STB;
  assign d_req = d_CYC & d_STB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  // ACK is checked before the CYC drop so an ACK on the drop cycle completes
  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          state_nx = last ? OWN_I : OWN_D;
        else if (i_req)
          state_nx = OWN_I;
        else if (d_req)
          state_nx = OWN_D;
      end
      OWN_I: begin
        if (m_ACK) begin
          last_nx  = 1'b0;
          state_nx = d_req ? OWN_D : IDLE;
        end else if (!i_CYC) begin
          state_nx = IDLE;
        end
      end
      OWN_D: begin
        if (m_ACK) begin
          last_nx  = 1'b1;
          state_nx = i_req ? OWN_I : IDLE;
        end else if (!d_CYC) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by rst so an async reset silences them at once
  always_comb begin
    m_CYC   = 1'b0;
    m_STB   = 1'b0;
    m_WE    = 1'b0;
    m_ADR   = '0;
    m_SEL   = '0;
    m_DAT_M = '0;
    i_DAT_S = '0;
    i_ACK   = 1'b0;
    i_RTY   = 1'b0;
    d_DAT_S = '0;
    d_ACK   = 1'b0;
    d_RTY   = 1'b0;
    grant   = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          i_RTY = i_req;
          d_RTY = d_req;
        end
        OWN_I: begin
          grant   = 2'b01;
          m_CYC   = i_CYC;
          m_STB   = i_STB;
          m_WE    = i_WE;
          m_ADR   = i_ADR;
          m_SEL   = i_SEL;
          m_DAT_M = i_DAT_M;
          i_DAT_S = m_DAT_S;
          i_ACK   = m_ACK;
          i_RTY   = m_RTY;
          d_RTY   = d_req;
        end
        OWN_D: begin
          grant   = 2'b10;
          m_CYC   = d_CYC;
          m_STB   = d_STB;
          m_WE    = d_WE;
          m_ADR   = d_ADR;
          m_SEL   = d_SEL;
          m_DAT_M = d_DAT_M;
          d_DAT_S = m_DAT_S;
          d_ACK   = m_ACK;
          d_RTY   = m_RTY;
          i_RTY   = i_req;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wishbone_arbiter.sv
// Directed bench for mem_wishbone_arbiter with a queue scoreboard
// for expected grant order and returned read data.
module tb_mem_wishbone_arbiter;

  logic         clk, rst;
  logic         i_CYC, i_STB, i_WE;
  logic [11:0]  i_ADR;
  logic [15:0]  i_SEL;
  logic [127:0] i_DAT_M, i_DAT_S;
  logic         i_ACK, i_RTY;
  logic         d_CYC, d_STB, d_WE;
  logic [11:0]  d_ADR;
  logic [15:0]  d_SEL;
  logic [127:0] d_DAT_M, d_DAT_S;
  logic         d_ACK, d_RTY;
  logic         m_CYC, m_STB, m_WE;
  logic [11:0]  m_ADR;
  logic [15:0]  m_SEL;
  logic [127:0] m_DAT_M, m_DAT_S;
  logic         m_ACK, m_RTY;
  logic [1:0]   grant;

  int vectors = 0;
  int errors  = 0;

  logic [1:0]   gq[$];
  logic [127:0] dq[$];

  mem_wishbone_arbiter dut (
    .clk(clk), .rst(rst),
    .i_CYC(i_CYC), .i_STB(i_STB), .i_WE(i_WE),
    .i_ADR(i_ADR), .i_SEL(i_SEL), .i_DAT_M(i_DAT_M),
    .i_DAT_S(i_DAT_S), .i_ACK(i_ACK), .i_RTY(i_RTY),
    .d_CYC(d_CYC), .d_STB(d_STB), .d_WE(d_WE),
    .d_ADR(d_ADR), .d_SEL(d_SEL), .d_DAT_M(d_DAT_M),
    .d_DAT_S(d_DAT_S), .d_ACK(d_ACK), .d_RTY(d_RTY),
    .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE),
    .m_ADR(m_ADR), .m_SEL(m_SEL), .m_DAT_M(m_DAT_M),
    .m_DAT_S(m_DAT_S), .m_ACK(m_ACK), .m_RTY(m_RTY),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0]   eg;
    logic [127:0] ed;
    rst = 1'b1;
    i_CYC = 0; i_STB = 0; i_WE = 0;
    i_ADR = '0; i_SEL = '0; i_DAT_M = '0;
    d_CYC = 0; d_STB = 0; d_WE = 0;
    d_ADR = '0; d_SEL = '0; d_DAT_M = '0;
    m_DAT_S = '0; m_ACK = 0; m_RTY = 0;

    // reset holds every output low even with a request present
    step();
    i_CYC = 1; i_STB = 1;
    settle();
    chk("rst_grant", 128'(grant), 128'(2'b00));
    chk("rst_mcyc", 128'(m_CYC), 128'(1'b0));
    chk("rst_irty", 128'(i_RTY), 128'(1'b0));
    i_CYC = 0; i_STB = 0;
    do_reset();

    // single read by I
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0A0; i_SEL = 16'hFFFF;
    settle();
    chk("t1_irty_req", 128'(i_RTY), 128'(1'b1));
    chk("t1_mcyc_req", 128'(m_CYC), 128'(1'b0));
    step();
    chk("t1_grant", 128'(grant), 128'(2'b01));
    chk("t1_mcyc", 128'(m_CYC), 128'(1'b1));
    chk("t1_madr", 128'(m_ADR), 128'(12'h0A0));
    m_ACK = 1;
    m_DAT_S = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    dq.push_back(128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    settle();
    chk("t1_iack", 128'(i_ACK), 128'(1'b1));
    ed = dq.pop_front();
    chk("t1_idat", i_DAT_S, ed);
    step();
    i_CYC = 0; i_STB = 0; m_ACK = 0; m_DAT_S = '0;
    settle();
    chk("t1_idle_grant", 128'(grant), 128'(2'b00));
    chk("t1_idle_mcyc", 128'(m_CYC), 128'(1'b0));

    // simultaneous I read and D write, back-to-back handoff
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h111;
    d_CYC = 1; d_STB = 1; d_WE = 1; d_ADR = 12'h3F0;
    d_SEL = 16'h0030; d_DAT_M = 128'h0123_4567_89AB_CDEF;
    settle();
    chk("t2_drty_idle", 128'(d_RTY), 128'(1'b1));
    step();
    chk("t2_grant_i", 128'(grant), 128'(2'b01));
    chk("t2_drty_own", 128'(d_RTY), 128'(1'b1));
    chk("t2_madr_i", 128'(m_ADR), 128'(12'h111));
    step();
    chk("t2_drty_wait", 128'(d_RTY), 128'(1'b1));
    m_ACK = 1;
    settle();
    chk("t2_iack", 128'(i_ACK), 128'(1'b1));
    chk("t2_dack", 128'(d_ACK), 128'(1'b0));
    step();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    settle();
    chk("t2_grant_d", 128'(grant), 128'(2'b10));
    chk("t2_madr_d", 128'(m_ADR), 128'(12'h3F0));
    chk("t2_msel_d", 128'(m_SEL), 128'(16'h0030));
    chk("t2_mwe_d", 128'(m_WE), 128'(1'b1));
    chk("t2_mdat_d", m_DAT_M, 128'h0123_4567_89AB_CDEF);
    m_ACK = 1;
    step();
    d_CYC = 0; d_STB = 0; d_WE = 0; m_ACK = 0;
    settle();
    chk("t2_idle", 128'(grant), 128'(2'b00));

    // fairness: continuous requests alternate I, D, I, D, I, D
    for (int k = 0; k < 6; k++)
      gq.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    i_CYC = 1; i_STB = 1; d_CYC = 1; d_STB = 1;
    step();
    for (int k = 0; k < 6; k++) begin
      eg = gq.pop_front();
      chk($sformatf("t3_grant%0d", k), 128'(grant), 128'(eg));
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("t3_lrty%0d_%0d", k, w),
            128'((eg == 2'b01) ? d_RTY : i_RTY), 128'(1'b1));
        step();
      end
      m_ACK = 1;
      settle();
      chk($sformatf("t3_ack%0d", k),
          128'((eg == 2'b01) ? i_ACK : d_ACK), 128'(1'b1));
      step();
      m_ACK = 0;
      settle();
    end
    i_CYC = 0; i_STB = 0; d_CYC = 0; d_STB = 0;
    step();
    chk("t3_idle", 128'(grant), 128'(2'b00));

    // D held off by slave RTY for 10 cycles while I waits
    d_CYC = 1; d_STB = 1;
    step();
    m_RTY = 1;
    i_CYC = 1; i_STB = 1;
    settle();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t4_drty%0d", c), 128'(d_RTY), 128'(1'b1));
      chk($sformatf("t4_irty%0d", c), 128'(i_RTY), 128'(1'b1));
      chk($sformatf("t4_grant%0d", c), 128'(grant), 128'(2'b10));
      step();
    end
    m_RTY = 0; m_ACK = 1;
    step();
    d_CYC = 0; d_STB = 0;
    settle();
    chk("t4_grant_i", 128'(grant), 128'(2'b01));
    step();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    settle();
    chk("t4_idle", 128'(grant), 128'(2'b00));

    // async reset while I owns
    i_CYC = 1; i_STB = 1;
    step();
    m_RTY = 1; d_CYC = 1; d_STB = 1;
    settle();
    chk("t5_grant_pre", 128'(grant), 128'(2'b01));
    rst = 1;
    #1;
    chk("t5_mcyc", 128'(m_CYC), 128'(1'b0));
    chk("t5_grant", 128'(grant), 128'(2'b00));
    chk("t5_irty", 128'(i_RTY), 128'(1'b0));
    chk("t5_drty", 128'(d_RTY), 128'(1'b0));
    i_CYC = 0; i_STB = 0; m_RTY = 0;
    #1;
    rst = 0;
    step();
    chk("t5_grant_d", 128'(grant), 128'(2'b10));

    // abort leaves the round-robin pointer alone
    m_ACK = 1;
    step();
    d_CYC = 0; d_STB = 0; m_ACK = 0;
    i_CYC = 1; i_STB = 1;
    step();
    chk("t6_grant_i", 128'(grant), 128'(2'b01));
    m_ACK = 1;
    step();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    d_CYC = 1; d_STB = 1;
    step();
    chk("t6_grant_d", 128'(grant), 128'(2'b10));
    d_CYC = 0; d_STB = 0;
    step();
    chk("t6_abort_idle", 128'(grant), 128'(2'b00));
    i_CYC = 1; i_STB = 1; d_CYC = 1; d_STB = 1;
    step();
    chk("t6_winner", 128'(grant), 128'(2'b10));
    i_CYC = 0; i_STB = 0; d_CYC = 0; d_STB = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
